// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, access sizes,
// exception codes and the latched-operation record.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2, ST_DONE = 2'd3} state_e;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_DWORD = 2'd3} size_e;
    typedef enum logic [1:0] {EXC_NONE = 2'd0, EXC_MISALIGN = 2'd1, EXC_TIMEOUT = 2'd2, EXC_ILLEGAL = 2'd3} exc_e;

    typedef struct packed {
        logic       we;
        size_e      size;
        logic       uns;
        logic [4:0] rd;
    } op_t;

    // Byte-enable pattern of an access before it is shifted to its lane offset.
    function automatic logic [7:0] size_mask(size_e sz);
        case (sz)
            SZ_BYTE: size_mask = 8'h01;
            SZ_HALF: size_mask = 8'h03;
            SZ_WORD: size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(size_e sz, logic [2:0] a);
        case (sz)
            SZ_HALF:  misaligned = a[0] != 1'b0;
            SZ_WORD:  misaligned = a[1:0] != 2'b00;
            SZ_DWORD: misaligned = a != 3'b000;
            default:  misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory request/response channel between the load/store unit and memory.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: shifts the addressed lanes down to bit 0 and
// zero- or sign-extends them to the full data width.
module load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]          rdata,
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  size_e                      size,
    input  logic                       uns,
    output logic [DATA_W-1:0]          data
);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              sgn;

    always_comb begin
        sh   = rdata >> {off, 3'b000};
        mask = '1;
        sgn  = sh[DATA_W-1];
        case (size)
            SZ_BYTE: begin mask = DATA_W'(8'hFF);         sgn = sh[7];  end
            SZ_HALF: begin mask = DATA_W'(16'hFFFF);      sgn = sh[15]; end
            SZ_WORD: begin mask = DATA_W'(32'hFFFF_FFFF); sgn = sh[31]; end
            default: ;
        endcase
        data = (sh & mask) | ({DATA_W{sgn & ~uns}} & ~mask);
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: checks an EX memory op, runs one bus transaction with a
// grant/response timeout, and returns an aligned writeback result.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_we,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [4:0]          in_rd,
    output logic                stallreq,
    mem_access_unit_if.master   mem,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                exc_valid,
    output logic [1:0]          exc_code
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e              state, state_nx;
    logic [7:0]          wait_cnt;
    op_t                 op;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, wb_data_q, load_data, wdata_rep;
    logic [BE_W-1:0]     be;
    logic [OFF_W-1:0]    off;
    logic                exc_valid_q;
    exc_e                exc_code_q;
    size_e               in_sz;
    logic                in_illegal, in_misal, accept, reject, tmo_hit, resp_take;

    assign in_sz      = size_e'(in_size);
    assign in_illegal = (DATA_W == 32) && (in_sz == SZ_DWORD);
    assign in_misal   = misaligned(in_sz, in_addr[2:0]);
    assign accept     = rst && (state == ST_IDLE) && in_valid && !in_illegal && !in_misal;
    assign reject     = (state == ST_IDLE) && in_valid && (in_illegal || in_misal);
    assign resp_take  = (state == ST_RESP) && mem.mem_rvalid;
    // A grant or response arriving on the last allowed cycle still wins.
    assign tmo_hit    = (wait_cnt == TMO_LAST) &&
                        (((state == ST_REQ) && !mem.mem_gnt) || ((state == ST_RESP) && !mem.mem_rvalid));
    assign off        = addr_q[OFF_W-1:0];

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata (mem.mem_rdata),
        .off   (off),
        .size  (op.size),
        .uns   (op.uns),
        .data  (load_data)
    );

    always_comb begin
        be        = BE_W'(size_mask(op.size)) << off;
        wdata_rep = '0;
        for (int i = 0; i < BE_W; i++) begin
            case (op.size)
                SZ_BYTE: wdata_rep[i*8 +: 8] = wdata_q[7:0];
                SZ_HALF: wdata_rep[i*8 +: 8] = wdata_q[(i % 2)*8 +: 8];
                SZ_WORD: wdata_rep[i*8 +: 8] = wdata_q[(i % 4)*8 +: 8];
                default: wdata_rep[i*8 +: 8] = wdata_q[i*8 +: 8];
            endcase
        end
    end

    always_comb begin
        state_nx       = state;
        stallreq       = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_be     = '0;
        mem.mem_wdata  = '0;
        wb_valid       = 1'b0;
        wb_we          = 1'b0;
        wb_rd          = '0;
        wb_data        = '0;
        case (state)
            ST_IDLE: if (accept) begin
                state_nx = ST_REQ;
                stallreq = 1'b1;
            end
            ST_REQ: begin
                stallreq      = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = op.we;
                mem.mem_addr  = addr_q & ~ADDR_W'(BE_W - 1);
                mem.mem_be    = be;
                mem.mem_wdata = wdata_rep;
                if (mem.mem_gnt) state_nx = op.we ? ST_DONE : ST_RESP;
                else if (tmo_hit) state_nx = ST_IDLE;
            end
            ST_RESP: begin
                stallreq = 1'b1;
                if (mem.mem_rvalid) state_nx = ST_DONE;
                else if (tmo_hit)   state_nx = ST_IDLE;
            end
            ST_DONE: begin
                wb_valid = 1'b1;
                wb_we    = ~op.we;
                wb_rd    = op.rd;
                wb_data  = wb_data_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            op          <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_NONE;
        end else begin
            state <= state_nx;
            if ((state_nx != state) || !((state == ST_REQ) || (state == ST_RESP))) wait_cnt <= '0;
            else wait_cnt <= wait_cnt + 8'd1;
            exc_valid_q <= 1'b0;
            exc_code_q  <= EXC_NONE;
            if (reject) begin
                exc_valid_q <= 1'b1;
                exc_code_q  <= in_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
            end else if (tmo_hit) begin
                exc_valid_q <= 1'b1;
                exc_code_q  <= EXC_TIMEOUT;
            end
            if (accept) begin
                op        <= '{we: in_we, size: in_sz, uns: in_unsigned, rd: in_rd};
                addr_q    <= in_addr;
                wdata_q   <= in_wdata;
                wb_data_q <= '0;
            end
            if (resp_take) wb_data_q <= load_data;
        end
    end

    assign exc_valid = exc_valid_q;
    assign exc_code  = exc_code_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a 32-bit unit with TIMEOUT=4 and a 64-bit unit with the
// default timeout, each driven by scripted memory handshakes.
module tb_mem_access_unit;
    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;

    // 32-bit instance
    logic        a_rst, a_in_valid, a_in_we, a_in_unsigned;
    logic [1:0]  a_in_size;
    logic [31:0] a_in_addr, a_in_wdata;
    logic [4:0]  a_in_rd;
    logic        a_stallreq, a_wb_valid, a_wb_we, a_exc_valid;
    logic [4:0]  a_wb_rd;
    logic [31:0] a_wb_data;
    logic [1:0]  a_exc_code;
    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) a_bus ();

    // 64-bit instance
    logic        b_rst, b_in_valid, b_in_we, b_in_unsigned;
    logic [1:0]  b_in_size;
    logic [31:0] b_in_addr;
    logic [63:0] b_in_wdata;
    logic [4:0]  b_in_rd;
    logic        b_stallreq, b_wb_valid, b_wb_we, b_exc_valid;
    logic [4:0]  b_wb_rd;
    logic [63:0] b_wb_data;
    logic [1:0]  b_exc_code;
    mem_access_unit_if #(.ADDR_W(32), .DATA_W(64)) b_bus ();

    // observations captured by run_a
    logic        o_stall_acc, o_req, o_we, o_stall_resp, o_wb_valid, o_wb_we, o_stall_done, o_wb_after;
    logic [31:0] o_addr, o_wd, o_wb_data;
    logic [3:0]  o_be;
    logic [4:0]  o_wb_rd;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_we(a_in_we), .in_size(a_in_size),
        .in_unsigned(a_in_unsigned), .in_addr(a_in_addr), .in_wdata(a_in_wdata), .in_rd(a_in_rd),
        .stallreq(a_stallreq), .mem(a_bus.master), .wb_valid(a_wb_valid), .wb_we(a_wb_we),
        .wb_rd(a_wb_rd), .wb_data(a_wb_data), .exc_valid(a_exc_valid), .exc_code(a_exc_code));

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_we(b_in_we), .in_size(b_in_size),
        .in_unsigned(b_in_unsigned), .in_addr(b_in_addr), .in_wdata(b_in_wdata), .in_rd(b_in_rd),
        .stallreq(b_stallreq), .mem(b_bus.master), .wb_valid(b_wb_valid), .wb_we(b_wb_we),
        .wb_rd(b_wb_rd), .wb_data(b_wb_data), .exc_valid(b_exc_valid), .exc_code(b_exc_code));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // One access on the 32-bit unit: grant after gw idle REQ cycles, and for
    // loads rvalid in the cycle right after the grant.
    task automatic run_a(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int gw,
                         input logic [31:0] rdata);
        @(negedge clk);
        a_in_valid = 1; a_in_we = we; a_in_size = sz; a_in_unsigned = uns;
        a_in_addr = addr; a_in_wdata = wd; a_in_rd = 5'd7;
        #1 o_stall_acc = a_stallreq;
        @(negedge clk);
        a_in_valid = 0;
        #1 o_req = a_bus.mem_req; o_we = a_bus.mem_we; o_addr = a_bus.mem_addr;
        o_be = a_bus.mem_be; o_wd = a_bus.mem_wdata;
        repeat (gw) @(negedge clk);
        a_bus.mem_gnt = 1;
        @(negedge clk);
        a_bus.mem_gnt = 0;
        if (!we) begin
            a_bus.mem_rvalid = 1; a_bus.mem_rdata = rdata;
            #1 o_stall_resp = a_stallreq;
            @(negedge clk);
            a_bus.mem_rvalid = 0; a_bus.mem_rdata = 32'h0;
        end
        #1 o_wb_valid = a_wb_valid; o_wb_we = a_wb_we; o_wb_data = a_wb_data;
        o_wb_rd = a_wb_rd; o_stall_done = a_stallreq;
        @(negedge clk);
        #1 o_wb_after = a_wb_valid;
    endtask

    task automatic test_reset();
        a_rst = 0; b_rst = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (a_stallreq !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", a_stallreq); end
        n_checks++; if (a_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", a_bus.mem_req); end
        n_checks++; if (a_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb: got %b want 0", a_wb_valid); end
        n_checks++; if (a_exc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exc: got %b want 0", a_exc_valid); end
        n_checks++; if (b_wb_data !== 64'h0) begin n_fail++; $display("FAIL rst_b_wbdata: got %h want 0", b_wb_data); end
        a_rst = 1; b_rst = 1;
    endtask

    task automatic test_word_load();
        run_a(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 2, 32'h8000_00F0);
        n_checks++; if (o_stall_acc !== 1'b1) begin n_fail++; $display("FAIL wl_stall_acc: got %b want 1", o_stall_acc); end
        n_checks++; if (o_req !== 1'b1) begin n_fail++; $display("FAIL wl_req: got %b want 1", o_req); end
        n_checks++; if (o_addr !== 32'h1004) begin n_fail++; $display("FAIL wl_addr: got %h want 1004", o_addr); end
        n_checks++; if (o_be !== 4'hF) begin n_fail++; $display("FAIL wl_be: got %h want f", o_be); end
        n_checks++; if (o_stall_resp !== 1'b1) begin n_fail++; $display("FAIL wl_stall_resp: got %b want 1", o_stall_resp); end
        n_checks++; if (o_wb_valid !== 1'b1) begin n_fail++; $display("FAIL wl_wb_valid: got %b want 1", o_wb_valid); end
        n_checks++; if (o_wb_data !== 32'h8000_00F0) begin n_fail++; $display("FAIL wl_wb_data: got %h want 800000f0", o_wb_data); end
        n_checks++; if (o_wb_we !== 1'b1) begin n_fail++; $display("FAIL wl_wb_we: got %b want 1", o_wb_we); end
        n_checks++; if (o_wb_rd !== 5'd7) begin n_fail++; $display("FAIL wl_wb_rd: got %0d want 7", o_wb_rd); end
        n_checks++; if (o_stall_done !== 1'b0) begin n_fail++; $display("FAIL wl_stall_done: got %b want 0", o_stall_done); end
        n_checks++; if (o_wb_after !== 1'b0) begin n_fail++; $display("FAIL wl_wb_pulse: got %b want 0", o_wb_after); end
    endtask

    task automatic test_sub_word_load();
        run_a(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, 0, 32'h80AB_CDEF);
        n_checks++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", o_be); end
        n_checks++; if (o_addr !== 32'h0) begin n_fail++; $display("FAIL sb_addr: got %h want 0", o_addr); end
        n_checks++; if (o_wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL sb_data: got %h want ffffff80", o_wb_data); end
        run_a(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 0, 32'h80AB_CDEF);
        n_checks++; if (o_wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL ub_data: got %h want 00000080", o_wb_data); end
        run_a(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 1, 32'hBEEF_1234);
        n_checks++; if (o_wb_data !== 32'hFFFF_BEEF) begin n_fail++; $display("FAIL sh_data: got %h want ffffbeef", o_wb_data); end
    endtask

    task automatic test_store();
        run_a(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000_1234, 1, 32'h0);
        n_checks++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL hs_be: got %b want 1100", o_be); end
        n_checks++; if (o_wd !== 32'h1234_1234) begin n_fail++; $display("FAIL hs_wdata: got %h want 12341234", o_wd); end
        n_checks++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL hs_mem_we: got %b want 1", o_we); end
        n_checks++; if (o_wb_valid !== 1'b1) begin n_fail++; $display("FAIL hs_wb_valid: got %b want 1", o_wb_valid); end
        n_checks++; if (o_wb_we !== 1'b0) begin n_fail++; $display("FAIL hs_wb_we: got %b want 0", o_wb_we); end
        run_a(1'b1, 2'd0, 1'b0, 32'h1, 32'h0000_00A5, 0, 32'h0);
        n_checks++; if (o_be !== 4'b0010) begin n_fail++; $display("FAIL bs_be: got %b want 0010", o_be); end
        n_checks++; if (o_wd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bs_wdata: got %h want a5a5a5a5", o_wd); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        a_in_valid = 1; a_in_we = 0; a_in_size = 2'd2; a_in_addr = 32'h1001;
        #1;
        n_checks++; if (a_stallreq !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b want 0", a_stallreq); end
        @(negedge clk);
        a_in_valid = 0;
        #1;
        n_checks++; if (a_exc_valid !== 1'b1) begin n_fail++; $display("FAIL mis_exc: got %b want 1", a_exc_valid); end
        n_checks++; if (a_exc_code !== 2'd1) begin n_fail++; $display("FAIL mis_code: got %0d want 1", a_exc_code); end
        n_checks++; if (a_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %b want 0", a_bus.mem_req); end
        @(negedge clk);
        a_in_valid = 1; a_in_size = 2'd3; a_in_addr = 32'h0;
        #1;
        n_checks++; if (a_exc_valid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", a_exc_valid); end
        @(negedge clk);
        a_in_valid = 0;
        #1;
        n_checks++; if (a_exc_code !== 2'd3) begin n_fail++; $display("FAIL ill_code: got %0d want 3", a_exc_code); end
        n_checks++; if (a_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL ill_req: got %b want 0", a_bus.mem_req); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        a_in_valid = 1; a_in_we = 0; a_in_size = 2'd2; a_in_addr = 32'h40;
        @(negedge clk);
        a_in_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (a_bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL to_req_held: got %b want 1", a_bus.mem_req); end
        n_checks++; if (a_exc_valid !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", a_exc_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (a_exc_valid !== 1'b1) begin n_fail++; $display("FAIL to_exc: got %b want 1", a_exc_valid); end
        n_checks++; if (a_exc_code !== 2'd2) begin n_fail++; $display("FAIL to_code: got %0d want 2", a_exc_code); end
        n_checks++; if (a_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b want 0", a_bus.mem_req); end
        n_checks++; if (a_stallreq !== 1'b0) begin n_fail++; $display("FAIL to_stall: got %b want 0", a_stallreq); end
        @(negedge clk);
        #1;
        n_checks++; if (a_wb_valid !== 1'b0) begin n_fail++; $display("FAIL to_wb: got %b want 0", a_wb_valid); end
    endtask

    task automatic test_ignored_inputs();
        @(negedge clk);
        a_in_valid = 1; a_in_we = 0; a_in_size = 2'd2; a_in_unsigned = 0; a_in_addr = 32'h20;
        @(negedge clk);
        a_in_addr = 32'h21; a_bus.mem_rvalid = 1; a_bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        a_in_valid = 0; a_bus.mem_rvalid = 0; a_bus.mem_gnt = 1;
        #1;
        n_checks++; if (a_exc_valid !== 1'b0) begin n_fail++; $display("FAIL busy_in_valid: got %b want 0", a_exc_valid); end
        @(negedge clk);
        a_bus.mem_gnt = 0; a_bus.mem_rvalid = 1; a_bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        a_bus.mem_rvalid = 0;
        #1;
        n_checks++; if (a_wb_valid !== 1'b1) begin n_fail++; $display("FAIL ign_wb_valid: got %b want 1", a_wb_valid); end
        n_checks++; if (a_wb_data !== 32'h1122_3344) begin n_fail++; $display("FAIL ign_wb_data: got %h want 11223344", a_wb_data); end
    endtask

    task automatic test_dword();
        @(negedge clk);
        b_in_valid = 1; b_in_we = 0; b_in_size = 2'd3; b_in_unsigned = 0; b_in_addr = 32'h8; b_in_rd = 5'd3;
        @(negedge clk);
        b_in_valid = 0;
        #1;
        n_checks++; if (b_bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL dw_addr: got %h want 8", b_bus.mem_addr); end
        n_checks++; if (b_bus.mem_be !== 8'hFF) begin n_fail++; $display("FAIL dw_be: got %h want ff", b_bus.mem_be); end
        b_bus.mem_gnt = 1;
        @(negedge clk);
        b_bus.mem_gnt = 0; b_bus.mem_rvalid = 1; b_bus.mem_rdata = 64'h8877_6655_4433_2211;
        @(negedge clk);
        b_bus.mem_rvalid = 0;
        #1;
        n_checks++; if (b_wb_data !== 64'h8877_6655_4433_2211) begin n_fail++; $display("FAIL dw_data: got %h want 8877665544332211", b_wb_data); end
        @(negedge clk);
        b_in_valid = 1; b_in_size = 2'd0; b_in_addr = 32'hD;
        @(negedge clk);
        b_in_valid = 0;
        #1;
        n_checks++; if (b_bus.mem_be !== 8'b0010_0000) begin n_fail++; $display("FAIL b64_be: got %b want 00100000", b_bus.mem_be); end
        b_bus.mem_gnt = 1;
        @(negedge clk);
        b_bus.mem_gnt = 0; b_bus.mem_rvalid = 1; b_bus.mem_rdata = 64'h0000_9A00_0000_0000;
        @(negedge clk);
        b_bus.mem_rvalid = 0;
        #1;
        n_checks++; if (b_wb_data !== 64'hFFFF_FFFF_FFFF_FF9A) begin n_fail++; $display("FAIL b64_data: got %h want ffffffffffffff9a", b_wb_data); end
    endtask

    task automatic test_reset_in_resp();
        @(negedge clk);
        b_in_valid = 1; b_in_we = 0; b_in_size = 2'd3; b_in_addr = 32'h8;
        @(negedge clk);
        b_in_valid = 0; b_bus.mem_gnt = 1;
        @(negedge clk);
        b_bus.mem_gnt = 0;
        #1;
        n_checks++; if (b_stallreq !== 1'b1) begin n_fail++; $display("FAIL rr_stall_resp: got %b want 1", b_stallreq); end
        b_rst = 0;
        @(negedge clk);
        b_bus.mem_rvalid = 1; b_bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        n_checks++; if (b_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_wb: got %b want 0", b_wb_valid); end
        n_checks++; if (b_stallreq !== 1'b0) begin n_fail++; $display("FAIL rr_stall: got %b want 0", b_stallreq); end
        n_checks++; if (b_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rr_req: got %b want 0", b_bus.mem_req); end
        n_checks++; if (b_bus.mem_be !== 8'h0) begin n_fail++; $display("FAIL rr_be: got %h want 0", b_bus.mem_be); end
        n_checks++; if (b_exc_valid !== 1'b0) begin n_fail++; $display("FAIL rr_exc: got %b want 0", b_exc_valid); end
        b_rst = 1;
        @(negedge clk);
        b_bus.mem_rvalid = 0;
        #1;
        n_checks++; if (b_wb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_wb_after: got %b want 0", b_wb_valid); end
        n_checks++; if (b_wb_data !== 64'h0) begin n_fail++; $display("FAIL rr_wbdata: got %h want 0", b_wb_data); end
    endtask

    initial begin
        a_rst = 0; a_in_valid = 0; a_in_we = 0; a_in_size = 0; a_in_unsigned = 0;
        a_in_addr = 0; a_in_wdata = 0; a_in_rd = 0;
        a_bus.mem_gnt = 0; a_bus.mem_rvalid = 0; a_bus.mem_rdata = 0;
        b_rst = 0; b_in_valid = 0; b_in_we = 0; b_in_size = 0; b_in_unsigned = 0;
        b_in_addr = 0; b_in_wdata = 0; b_in_rd = 0;
        b_bus.mem_gnt = 0; b_bus.mem_rvalid = 0; b_bus.mem_rdata = 0;
        test_reset();
        test_word_load();
        test_sub_word_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_ignored_inputs();
        test_dword();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
